// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among NREQ requesters.
// Optional completed-comparison counter enabled by defining CMP_SHARE_STATS_EN.
module cmp_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  done,
    output logic                  Equal,
    output logic                  A_more,
    output logic                  B_more
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [15:0]           cmp_count
`endif
);

    // state | meaning
    // IDLE  | no owner, arbitrating pending requests
    // BUSY  | operands captured, owner's req checked before comparing
    // DONE  | result registered, done pulse high, pointer advances
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             owner_req;

    // Walk downward so the nearest requester at or after ptr is the last one written.
    always_comb begin : rr_search
        int j;
        j          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    assign owner_req = req[owner];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            done   <= 1'b0;
            Equal  <= 1'b0;
            A_more <= 1'b0;
            B_more <= 1'b0;
            ptr    <= '0;
            owner  <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner <= pick_idx;
                        op_a  <= a_bus[pick_idx*WIDTH +: WIDTH];
                        op_b  <= b_bus[pick_idx*WIDTH +: WIDTH];
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (owner_req) begin
                        Equal  <= (op_a == op_b);
                        A_more <= (op_a > op_b);
                        B_more <= (op_b > op_a);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        // Abandoned: results and pointer are left untouched.
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    grant <= '0;
                    ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CMP_SHARE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_count <= '0;
        end else if (state == ST_BUSY && owner_req && cmp_count != 16'hFFFF) begin
            cmp_count <= cmp_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: cycle-exact vector table plus reset and exhaustive sequences.
// Checks cmp_count when built with CMP_SHARE_STATS_EN.
module tb_cmp_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] a_bus;
    logic [11:0] b_bus;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        Equal;
    logic        A_more;
    logic        B_more;
`ifdef CMP_SHARE_STATS_EN
    logic [15:0] cmp_count;
`endif

    int n_checks;
    int n_errors;

    cmp_share_arbiter #(.NREQ(4), .WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .Equal  (Equal),
        .A_more (A_more),
        .B_more (B_more)
`ifdef CMP_SHARE_STATS_EN
        ,
        .cmp_count (cmp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  grant;
        logic        busy;
        logic        done;
        logic [2:0]  flags;   // {Equal, A_more, B_more}
    } vec_t;

    vec_t vt[$];

    function automatic logic [11:0] pk(input logic [2:0] v3, input logic [2:0] v2,
                                       input logic [2:0] v1, input logic [2:0] v0);
        return {v3, v2, v1, v0};
    endfunction

    function void add(input logic [3:0] r, input logic [11:0] a, input logic [11:0] b,
                      input logic [3:0] g, input logic bz, input logic dn, input logic [2:0] f);
        vt.push_back('{req: r, a: a, b: b, grant: g, busy: bz, done: dn, flags: f});
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] outs;
        return {7'd0, grant, busy, done, Equal, A_more, B_more};
    endfunction

    logic [11:0] ra, rb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = '0;
        a_bus = '0;
        b_bus = '0;

        // Port operands for round-robin: 1<4, 6>2, 3==3, 7>0.
        ra = pk(3'd7, 3'd3, 3'd6, 3'd1);
        rb = pk(3'd0, 3'd3, 3'd2, 3'd4);
        for (int i = 0; i < 14; i++) begin
            case (i % 3)
                0: add(4'b1111, ra, rb, 4'b0001 << (i / 3 % 4), 1'b1, 1'b0,
                       (i == 0) ? 3'b000 : (i == 3) ? 3'b001 : (i == 6) ? 3'b010 : (i == 9) ? 3'b100 : 3'b010);
                1: add(4'b1111, ra, rb, 4'b0001 << (i / 3 % 4), 1'b1, 1'b1,
                       (i == 1) ? 3'b001 : (i == 4) ? 3'b010 : (i == 7) ? 3'b100 : (i == 10) ? 3'b010 : 3'b001);
                default: add(4'b1111, ra, rb, 4'b0000, 1'b0, 1'b0,
                       (i == 2) ? 3'b001 : (i == 5) ? 3'b010 : (i == 8) ? 3'b100 : 3'b010);
            endcase
        end
        add(4'b0000, ra, rb, 4'b0000, 1'b0, 1'b0, 3'b001);
        // Single request on port 2: 5 > 3.
        add(4'b0100, pk(3'd0, 3'd5, 3'd0, 3'd0), pk(3'd0, 3'd3, 3'd0, 3'd0), 4'b0100, 1'b1, 1'b0, 3'b001);
        add(4'b0100, pk(3'd0, 3'd5, 3'd0, 3'd0), pk(3'd0, 3'd3, 3'd0, 3'd0), 4'b0100, 1'b1, 1'b1, 3'b010);
        add(4'b0000, '0, '0, 4'b0000, 1'b0, 1'b0, 3'b010);
        // Port 0: 7==7, 2<6, 0==0.
        add(4'b0001, pk(3'd0, 3'd0, 3'd0, 3'd7), pk(3'd0, 3'd0, 3'd0, 3'd7), 4'b0001, 1'b1, 1'b0, 3'b010);
        add(4'b0001, pk(3'd0, 3'd0, 3'd0, 3'd7), pk(3'd0, 3'd0, 3'd0, 3'd7), 4'b0001, 1'b1, 1'b1, 3'b100);
        add(4'b0000, '0, '0, 4'b0000, 1'b0, 1'b0, 3'b100);
        add(4'b0001, pk(3'd0, 3'd0, 3'd0, 3'd2), pk(3'd0, 3'd0, 3'd0, 3'd6), 4'b0001, 1'b1, 1'b0, 3'b100);
        add(4'b0001, pk(3'd0, 3'd0, 3'd0, 3'd2), pk(3'd0, 3'd0, 3'd0, 3'd6), 4'b0001, 1'b1, 1'b1, 3'b001);
        add(4'b0000, '0, '0, 4'b0000, 1'b0, 1'b0, 3'b001);
        add(4'b0001, '0, '0, 4'b0001, 1'b1, 1'b0, 3'b001);
        add(4'b0001, '0, '0, 4'b0001, 1'b1, 1'b1, 3'b100);
        add(4'b0000, '0, '0, 4'b0000, 1'b0, 1'b0, 3'b100);
        // Abandon on port 3 (ptr stays 1), then 1001 must pick port 3; operand change after capture ignored.
        add(4'b1000, '0, pk(3'd5, 3'd0, 3'd0, 3'd0), 4'b1000, 1'b1, 1'b0, 3'b100);
        add(4'b0000, '0, pk(3'd5, 3'd0, 3'd0, 3'd0), 4'b0000, 1'b0, 1'b0, 3'b100);
        add(4'b1001, '0, pk(3'd5, 3'd0, 3'd0, 3'd0), 4'b1000, 1'b1, 1'b0, 3'b100);
        add(4'b1001, pk(3'd7, 3'd0, 3'd0, 3'd0), pk(3'd5, 3'd0, 3'd0, 3'd0), 4'b1000, 1'b1, 1'b1, 3'b001);
        add(4'b0000, '0, '0, 4'b0000, 1'b0, 1'b0, 3'b001);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_outs", outs(), 16'h0000);

        // Async reset while port 1 is in BUSY.
        req = 4'b0010;
        tick();
        check("pre_reset_grant", outs(), {7'd0, 4'b0010, 1'b1, 1'b0, 3'b000});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 16'h0000);
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_idle_%0d", i), outs(), 16'h0000);
        end

        // Cycle-exact vector table.
        for (int i = 0; i < vt.size(); i++) begin
            req   = vt[i].req;
            a_bus = vt[i].a;
            b_bus = vt[i].b;
            tick();
            check($sformatf("vec_%0d", i), outs(),
                  {7'd0, vt[i].grant, vt[i].busy, vt[i].done, vt[i].flags});
        end

`ifdef CMP_SHARE_STATS_EN
        check("cmp_count_10", cmp_count, 16'd10);
`endif

        // Exhaustive operand pairs via port 1.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                a_bus = {3'd0, 3'd0, 3'(a), 3'd0};
                b_bus = {3'd0, 3'd0, 3'(b), 3'd0};
                req   = 4'b0010;
                tick();
                tick();
                check($sformatf("exh_a%0d_b%0d", a, b), outs(),
                      {7'd0, 4'b0010, 1'b1, 1'b1, (a == b), (a > b), (b > a)});
                req = 4'b0000;
                tick();
            end
        end

`ifdef CMP_SHARE_STATS_EN
        check("cmp_count_74", cmp_count, 16'd74);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
